// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one memory request/response channel, seen from either end.
interface mem_arbiter_if;
  logic req, we, gnt, rvalid, err;
  logic [31:0] addr, wdata, rdata;
  logic [3:0] be;
  modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata, err);
  modport slave (input req, addr, we, be, wdata, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one slave port between two masters, one transaction in flight, with request timeout.
module mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave m0,
  mem_arbiter_if.slave m1,
  mem_arbiter_if.master s
);
  typedef enum logic [2:0] {IDLE, REQ, RESP, ERR_GNT, ERR_RSP} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT);
  state_t state, nxt;
  logic owner, last, pick, any_req, gnt_p, rsp_p;
  logic [7:0] cnt;
  logic [31:0] rdata;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      owner <= 1'b0;
      last <= 1'b1;
      cnt <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && any_req) owner <= pick;
      if (state == REQ && nxt != REQ) last <= owner;
      cnt <= (state == REQ && nxt == REQ) ? cnt + 8'd1 : 8'd0;
    end
  end
  always_comb begin
    any_req = m0.req | m1.req;
    pick = (m0.req & m1.req) ? ~last : m1.req;
    nxt = state;
    case (state)
      IDLE: nxt = any_req ? REQ : IDLE;
      REQ: nxt = s.gnt ? RESP : (cnt >= LIMIT ? ERR_GNT : REQ);
      RESP: nxt = s.rvalid ? IDLE : RESP;
      ERR_GNT: nxt = ERR_RSP;
      default: nxt = IDLE;
    endcase
  end
  // Outputs are forced low while rst is held, before the state register has been cleared.
  assign gnt_p = !rst && ((state == REQ && s.gnt) || state == ERR_GNT);
  assign rsp_p = !rst && ((state == RESP && s.rvalid) || state == ERR_RSP);
  assign rdata = (rsp_p && state == RESP) ? s.rdata : '0;
  assign s.req = !rst && state == REQ && !s.gnt;
  assign s.addr = owner ? m1.addr : m0.addr;
  assign s.we = owner ? m1.we : m0.we;
  assign s.be = owner ? m1.be : m0.be;
  assign s.wdata = owner ? m1.wdata : m0.wdata;
  assign m0.gnt = gnt_p & ~owner;
  assign m1.gnt = gnt_p & owner;
  assign m0.rvalid = rsp_p & ~owner;
  assign m1.rvalid = rsp_p & owner;
  assign m0.rdata = rdata;
  assign m1.rdata = rdata;
  assign m0.err = rsp_p && state == ERR_RSP;
  assign m1.err = rsp_p && state == ERR_RSP;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, writes, timeout and reset abandonment.
module tb_mem_arbiter;
  logic clk, rst, gnt_en, rv_en;
  int passed, total, cyc, g_prev, n;
  mem_arbiter_if m0_bus ();
  mem_arbiter_if m1_bus ();
  mem_arbiter_if s_bus ();
  mem_arbiter #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .m0(m0_bus), .m1(m1_bus), .s(s_bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Zero-wait slave: grants the cycle after s_req, responds the cycle after grant.
  always_ff @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      s_bus.gnt <= 1'b0;
      s_bus.rvalid <= 1'b0;
    end else begin
      s_bus.gnt <= gnt_en & s_bus.req;
      s_bus.rvalid <= rv_en & s_bus.gnt;
    end
  end
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  initial begin
    passed = 0; total = 0; cyc = 0;
    gnt_en = 1'b1; rv_en = 1'b1; rst = 1'b1;
    s_bus.rdata = 32'hCAFEF00D; s_bus.err = 1'b0;
    m0_bus.req = 1'b1; m0_bus.addr = '0; m0_bus.we = 1'b0; m0_bus.be = '0; m0_bus.wdata = '0;
    m1_bus.req = 1'b0; m1_bus.addr = '0; m1_bus.we = 1'b0; m1_bus.be = '0; m1_bus.wdata = '0;
    tick();
    tick();
    chk("rst_sreq", {31'd0, s_bus.req}, 0);
    chk("rst_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 0);
    chk("rst_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 0);
    chk("rst_err", {31'd0, m0_bus.err}, 0);
    chk("rst_rdata", m0_bus.rdata, 0);
    m0_bus.req = 1'b0; rst = 1'b0;
    tick();
    chk("idle_sreq", {31'd0, s_bus.req}, 0);
    m1_bus.req = 1'b1; m1_bus.addr = 32'h0000_2010;
    tick();
    chk("rd_sreq", {31'd0, s_bus.req}, 1);
    chk("rd_saddr", s_bus.addr, 32'h0000_2010);
    chk("rd_swe", {31'd0, s_bus.we}, 0);
    chk("rd_gnt_early", {30'd0, m1_bus.gnt, m0_bus.gnt}, 0);
    tick();
    chk("rd_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 2'b10);
    chk("rd_sreq_drop", {31'd0, s_bus.req}, 0);
    m1_bus.req = 1'b0;
    tick();
    chk("rd_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 2'b10);
    chk("rd_rdata", m1_bus.rdata, 32'hCAFEF00D);
    chk("rd_err", {31'd0, m1_bus.err}, 0);
    tick();
    chk("rd_idle_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 0);
    chk("rd_idle_rdata", m1_bus.rdata, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m0_bus.req = 1'b1; m1_bus.req = 1'b1;
    g_prev = 0;
    for (int t = 0; t < 4; t++) begin
      n = 0;
      tick();
      while (!(m0_bus.gnt | m1_bus.gnt) && n < 10) begin
        tick();
        n++;
      end
      chk("rr_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, (t % 2) ? 2'b10 : 2'b01);
      if (t > 0) chk("rr_period", cyc - g_prev, 4);
      g_prev = cyc;
    end
    m0_bus.req = 1'b0; m1_bus.req = 1'b0;
    tick();
    chk("rr_last_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 2'b10);
    tick();
    m0_bus.req = 1'b1; m0_bus.we = 1'b1; m0_bus.be = 4'b0101;
    m0_bus.wdata = 32'h1122_3344; m0_bus.addr = 32'h0000_0100;
    tick();
    chk("wr_sreq", {31'd0, s_bus.req}, 1);
    chk("wr_swe", {31'd0, s_bus.we}, 1);
    chk("wr_sbe", {28'd0, s_bus.be}, 4'b0101);
    chk("wr_swdata", s_bus.wdata, 32'h1122_3344);
    tick();
    chk("wr_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 2'b01);
    chk("wr_sreq_once", {31'd0, s_bus.req}, 0);
    m0_bus.req = 1'b0; m0_bus.we = 1'b0;
    tick();
    chk("wr_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 2'b01);
    chk("wr_err", {31'd0, m0_bus.err}, 0);
    tick();
    gnt_en = 1'b0;
    m1_bus.req = 1'b1; m1_bus.addr = 32'h0000_9000;
    tick();
    chk("to_sreq", {31'd0, s_bus.req}, 1);
    n = 1;
    while (!m1_bus.gnt && n < 40) begin
      tick();
      n++;
    end
    chk("to_latency", n - 1, 16);
    chk("to_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 2'b10);
    chk("to_gnt_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 0);
    m1_bus.req = 1'b0;
    tick();
    chk("to_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 2'b10);
    chk("to_err", {31'd0, m1_bus.err}, 1);
    chk("to_rdata", m1_bus.rdata, 0);
    tick();
    chk("to_idle_err", {31'd0, m1_bus.err}, 0);
    gnt_en = 1'b1; rv_en = 1'b0;
    m0_bus.req = 1'b1; m0_bus.addr = 32'h0000_0040;
    tick();
    tick();
    chk("ab_gnt", {30'd0, m1_bus.gnt, m0_bus.gnt}, 2'b01);
    m0_bus.req = 1'b0;
    tick();
    chk("ab_wait", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0; rv_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_quiet", {28'd0, m1_bus.gnt, m0_bus.gnt, m1_bus.rvalid, m0_bus.rvalid}, 0);
    end
    m0_bus.req = 1'b1; m1_bus.req = 1'b1;
    tick();
    tick();
    chk("ab_prio", {30'd0, m1_bus.gnt, m0_bus.gnt}, 2'b01);
    m0_bus.req = 1'b0;
    tick();
    chk("ab_rvalid", {30'd0, m1_bus.rvalid, m0_bus.rvalid}, 2'b01);
    m1_bus.req = 1'b0;
    tick();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: cycles in REQ without s_gnt before a bus error is returned; range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 m0_req, m1_req  input  1 each  master request; held with address/control stable until that master's m_gnt.
REQ-005 m0_addr/m1_addr  input  32; m0_we/m1_we  input  1; m0_be/m1_be  input  4; m0_wdata/m1_wdata  input  32  master transfer fields.
REQ-006 m0_gnt, m1_gnt  output  1 each  request accepted; one-cycle pulse.
REQ-007 m0_rvalid, m1_rvalid  output  1 each  response valid; one-cycle pulse, also issued for writes.
REQ-008 m_rdata  output  32  shared read data, valid only with an m_rvalid.
REQ-009 m_err  output  1  qualifies m0_rvalid/m1_rvalid: response is a timeout error.
REQ-010 s_req  output  1; s_addr  output  32; s_we  output  1; s_be  output  4; s_wdata  output  32  slave request port.
REQ-011 s_gnt  input  1; s_rvalid  input  1; s_rdata  input  32  slave handshake and read data.

Function
REQ-012 The block SHALL share one slave port between two masters, with at most one transaction outstanding.
REQ-013 States: IDLE, REQ, RESP, ERR_GNT, ERR_RSP; 1-bit owner register; 1-bit last register; 8-bit timeout counter.
REQ-014 IDLE: when any m_req is high, the block SHALL latch owner and enter REQ next cycle; otherwise it SHALL stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a single requester wins; when both request, the master != last wins.
REQ-016 last SHALL be updated to owner on entry to RESP or ERR_GNT.
REQ-017 s_addr/s_we/s_be/s_wdata SHALL be muxed combinationally from the owner's inputs in every state.
REQ-018 s_req SHALL equal (state==REQ) && !s_gnt, so the slave sees exactly one accepted request.
REQ-019 In REQ with s_gnt high, m<owner>_gnt SHALL pulse that cycle, the counter SHALL clear, and the state SHALL go to RESP.
REQ-020 In REQ without s_gnt, the counter SHALL increment; on reaching TIMEOUT the state SHALL go to ERR_GNT.
REQ-021 In RESP with s_rvalid high, m<owner>_rvalid SHALL pulse, m_rdata SHALL equal s_rdata, m_err SHALL be 0, and the state SHALL go to IDLE.
REQ-022 RESP SHALL wait indefinitely for s_rvalid.
REQ-023 ERR_GNT SHALL pulse m<owner>_gnt for one cycle, then go to ERR_RSP.
REQ-024 ERR_RSP SHALL pulse m<owner>_rvalid with m_err=1 and m_rdata=0, then go to IDLE.
REQ-025 Latency with the zero-wait slave: m_req seen in IDLE at cycle N -> s_req at N+1 -> m_gnt at N+2 -> m_rvalid at N+3; back-to-back issue gives one transaction per 4 cycles.
REQ-026 A master's gnt/rvalid SHALL never assert while the other master owns the bus.
REQ-027 In IDLE, m_rdata and m_err SHALL be 0.
REQ-028 s_gnt or s_rvalid arriving in a state not expecting it SHALL be ignored without a state change.

Reset
REQ-029 While rst=1 at a clock edge, the block SHALL set state=IDLE, owner=0, last=1 (m0 wins the first contention), and counter=0.
REQ-030 During reset, all m_gnt, m_rvalid, m_err and s_req SHALL be 0.
REQ-031 Reset asserted mid-transaction SHALL abandon it, with no gnt or rvalid pulse afterwards.

Verification
REQ-032 m1 read 0x00002010 alone, slave rdata=0xCAFEF00D -> s_req at N+1, m1_gnt at N+2, m1_rvalid with m_rdata=0xCAFEF00D at N+3, m0 outputs 0.
REQ-033 m0 and m1 request together after reset -> m0 served first, m1 next; with continuous requests, grants alternate m0,m1,m0,m1.
REQ-034 m0 write be=4'b0101 wdata=0x11223344 -> s_we=1, s_be=0101 for one s_req cycle; m0_rvalid issued with m_err=0.
REQ-035 m1 request to an unmapped address 0x00009000 (no s_gnt), TIMEOUT=15 -> m1_gnt 16 cycles after entering REQ, m1_rvalid with m_err=1 and m_rdata=0 one cycle later.
REQ-036 rst pulsed in RESP before s_rvalid -> no m_rvalid; next request is handled normally from IDLE with m0 priority.
